// File: rtl/axi2per_rw_sched.sv
// Read/write scheduler for the AXI-to-peripheral path: arbitrates AR against AW+W,
// holds the winner in a one-entry command register and bounds outstanding transactions.
module axi2per_rw_sched #(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_ID_WIDTH    = 3,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mode_i,
  input  logic                      ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  output logic                      ar_ready_o,
  input  logic                      aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  output logic                      aw_ready_o,
  input  logic                      w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
  input  logic [AXI_STRB_WIDTH-1:0] w_strb_i,
  output logic                      w_ready_o,
  output logic                      cmd_valid_o,
  output logic                      cmd_read_o,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   cmd_id_o,
  output logic [31:0]               cmd_wdata_o,
  output logic [3:0]                cmd_be_o,
  input  logic                      cmd_ready_i,
  input  logic                      done_i,
  output logic [3:0]                outstanding_o,
  output logic                      busy_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, CMD = 1'b1} state_e;

  localparam logic [3:0] MaxOut    = 4'(MAX_OUTSTANDING);
  localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

  state_e      state_r, state_next_s;
  logic [3:0]  out_cnt_r;
  logic [7:0]  starve_r;
  logic        last_wr_r;
  logic        rd_elig_s, wr_elig_s, arb_en_s;
  logic        grant_rd_s, grant_wr_s;
  logic        hs_s, done_eff_s;

  logic                      cmd_read_r;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_r;
  logic [AXI_ID_WIDTH-1:0]   cmd_id_r;
  logic [31:0]               cmd_wdata_r;
  logic [3:0]                cmd_be_r;

  // Arbitration: readies are gated by reset so every output is low while rst_ni is low
  always_comb begin
    rd_elig_s  = ar_valid_i;
    wr_elig_s  = aw_valid_i & w_valid_i;
    arb_en_s   = rst_ni & (state_r == IDLE) & (out_cnt_r < MaxOut);
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (arb_en_s) begin
      if (rd_elig_s && wr_elig_s) begin
        if (mode_i) begin
          if (starve_r == StarveLim) grant_wr_s = 1'b1;
          else                       grant_rd_s = 1'b1;
        end else begin
          if (last_wr_r) grant_rd_s = 1'b1;
          else           grant_wr_s = 1'b1;
        end
      end else if (rd_elig_s) begin
        grant_rd_s = 1'b1;
      end else if (wr_elig_s) begin
        grant_wr_s = 1'b1;
      end else begin
        grant_rd_s = 1'b0;
      end
    end else begin
      grant_wr_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = (grant_rd_s || grant_wr_s) ? CMD : IDLE;
      CMD:     state_next_s = cmd_ready_i ? IDLE : CMD;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: readies only in the capture cycle, AW and W always together
  always_comb begin
    ar_ready_o = grant_rd_s;
    aw_ready_o = grant_wr_s;
    w_ready_o  = grant_wr_s;
  end

  assign hs_s       = (state_r == CMD) & cmd_ready_i;
  assign done_eff_s = done_i & (out_cnt_r != 4'd0);

  // Command register: loaded on a grant, held stable through the CMD state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_read_r  <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_id_r    <= '0;
      cmd_wdata_r <= 32'd0;
      cmd_be_r    <= 4'd0;
      last_wr_r   <= 1'b1;
    end else if (grant_rd_s) begin
      cmd_read_r  <= 1'b1;
      cmd_addr_r  <= ar_addr_i;
      cmd_id_r    <= ar_id_i;
      cmd_wdata_r <= 32'd0;
      cmd_be_r    <= 4'd0;
      last_wr_r   <= 1'b0;
    end else if (grant_wr_s) begin
      cmd_read_r  <= 1'b0;
      cmd_addr_r  <= aw_addr_i;
      cmd_id_r    <= aw_id_i;
      cmd_wdata_r <= aw_addr_i[2] ? w_data_i[63:32] : w_data_i[31:0];
      cmd_be_r    <= aw_addr_i[2] ? w_strb_i[7:4]   : w_strb_i[3:0];
      last_wr_r   <= 1'b1;
    end
  end

  // Outstanding counter: simultaneous issue and completion cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      out_cnt_r <= 4'd0;
    else if (hs_s && !done_eff_s)     out_cnt_r <= out_cnt_r + 4'd1;
    else if (!hs_s && done_eff_s)     out_cnt_r <= out_cnt_r - 4'd1;
  end

  // Write starvation counter, active only under read-priority policy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_r <= 8'd0;
    end else if (mode_i) begin
      if (grant_wr_s)                                        starve_r <= 8'd0;
      else if (grant_rd_s && wr_elig_s && starve_r < StarveLim) starve_r <= starve_r + 8'd1;
    end
  end

  assign cmd_valid_o   = (state_r == CMD);
  assign cmd_read_o    = cmd_read_r;
  assign cmd_addr_o    = cmd_addr_r;
  assign cmd_id_o      = cmd_id_r;
  assign cmd_wdata_o   = cmd_wdata_r;
  assign cmd_be_o      = cmd_be_r;
  assign outstanding_o = out_cnt_r;
  assign busy_o        = (state_r == CMD) | (out_cnt_r != 4'd0);

endmodule

// File: tb/tb_axi2per_rw_sched.sv
// Directed self-checking bench for axi2per_rw_sched (MAX_OUTSTANDING=3, STARVE_LIMIT=3).
module tb_axi2per_rw_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mode_i;
  logic        ar_valid_i, aw_valid_i, w_valid_i;
  logic [31:0] ar_addr_i, aw_addr_i;
  logic [2:0]  ar_id_i, aw_id_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        ar_ready_o, aw_ready_o, w_ready_o;
  logic        cmd_valid_o, cmd_read_o, cmd_ready_i, done_i, busy_o;
  logic [31:0] cmd_addr_o, cmd_wdata_o;
  logic [2:0]  cmd_id_o;
  logic [3:0]  cmd_be_o, outstanding_o;

  int n_checks = 0;
  int n_errors = 0;
  bit auto_done = 1'b0;

  always #5 clk_i = ~clk_i;

  axi2per_rw_sched #(.MAX_OUTSTANDING(3), .STARVE_LIMIT(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i),
    .ar_valid_i(ar_valid_i), .ar_addr_i(ar_addr_i), .ar_id_i(ar_id_i), .ar_ready_o(ar_ready_o),
    .aw_valid_i(aw_valid_i), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i), .aw_ready_o(aw_ready_o),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_ready_o(w_ready_o),
    .cmd_valid_o(cmd_valid_o), .cmd_read_o(cmd_read_o), .cmd_addr_o(cmd_addr_o),
    .cmd_id_o(cmd_id_o), .cmd_wdata_o(cmd_wdata_o), .cmd_be_o(cmd_be_o),
    .cmd_ready_i(cmd_ready_i), .done_i(done_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock; done_i pulses in the cycle after a handshake when auto_done is set
  task automatic step();
    logic hs;
    hs = cmd_valid_o & cmd_ready_i;
    @(posedge clk_i);
    #1;
    done_i = auto_done & hs;
  endtask

  task automatic clear_inputs();
    mode_i = 1'b0; ar_valid_i = 1'b0; aw_valid_i = 1'b0; w_valid_i = 1'b0;
    ar_addr_i = 32'd0; aw_addr_i = 32'd0; ar_id_i = 3'd0; aw_id_i = 3'd0;
    w_data_i = 64'd0; w_strb_i = 8'd0; cmd_ready_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drive_both();
    ar_valid_i = 1'b1; ar_addr_i = 32'h10; ar_id_i = 3'd1;
    aw_valid_i = 1'b1; aw_addr_i = 32'h24; aw_id_i = 3'd2;
    w_valid_i = 1'b1; w_data_i = 64'hAAAA_BBBB_CCCC_DDDD; w_strb_i = 8'h5C;
    cmd_ready_i = 1'b1;
  endtask

  initial begin
    int g;
    int n_hs;
    bit hit;
    rst_ni = 1'b0;
    clear_inputs();
    ar_valid_i = 1'b1;
    #12;
    check("rst_cmd_valid", cmd_valid_o, 1'b0);
    check("rst_outstanding", outstanding_o, 4'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ar_ready", ar_ready_o, 1'b0);
    do_reset();

    // Round-robin: R,W,R,W with upper lane selected for aw_addr 0x24
    auto_done = 1'b1;
    drive_both();
    #1;
    check("t1_first_ar_ready", ar_ready_o, 1'b1);
    check("t1_first_aw_ready", aw_ready_o, 1'b0);
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      step();
      if (cmd_valid_o) begin
        check("t1_kind", cmd_read_o, (g % 2 == 0) ? 1'b1 : 1'b0);
        if (g % 2 == 1) begin
          check("t1_w_addr", cmd_addr_o, 32'h24);
          check("t1_w_id", cmd_id_o, 3'd2);
          check("t1_w_data", cmd_wdata_o, 32'hAAAA_BBBB);
          check("t1_w_be", cmd_be_o, 4'h5);
        end else begin
          check("t1_r_addr", cmd_addr_o, 32'h10);
          check("t1_r_data", cmd_wdata_o, 32'd0);
        end
        g++;
      end
    end
    check("t1_grants", g, 4);

    // Read priority with anti-starvation: R,R,R,W,R,R,R,W
    do_reset();
    drive_both();
    mode_i = 1'b1;
    g = 0;
    for (int c = 0; c < 60 && g < 8; c++) begin
      step();
      if (cmd_valid_o) begin
        check("t2_kind", cmd_read_o, (g % 4 != 3) ? 1'b1 : 1'b0);
        g++;
      end
    end
    check("t2_grants", g, 8);

    // Outstanding limit without completions
    do_reset();
    auto_done = 1'b0;
    ar_valid_i = 1'b1; ar_addr_i = 32'h30; cmd_ready_i = 1'b1;
    n_hs = 0;
    for (int c = 0; c < 16; c++) begin
      if (cmd_valid_o && cmd_ready_i) n_hs++;
      step();
    end
    check("t3_handshakes", n_hs, 3);
    check("t3_outstanding", outstanding_o, 4'd3);
    check("t3_ar_ready_blocked", ar_ready_o, 1'b0);
    check("t3_busy", busy_o, 1'b1);
    done_i = 1'b1;
    step();
    check("t3_after_done_cnt", outstanding_o, 4'd2);
    check("t3_after_done_ready", ar_ready_o, 1'b1);
    step();
    check("t3_recapture", cmd_valid_o, 1'b1);

    // Downstream backpressure: command held stable
    do_reset();
    ar_valid_i = 1'b1; ar_addr_i = 32'h44; ar_id_i = 3'd5;
    step();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", cmd_valid_o, 1'b1);
      check("t4_hold_addr", cmd_addr_o, 32'h44);
      check("t4_hold_id", cmd_id_o, 3'd5);
      check("t4_hold_ar_ready", ar_ready_o, 1'b0);
      if (k < 4) step();
    end
    cmd_ready_i = 1'b1;
    step();
    check("t4_released", cmd_valid_o, 1'b0);
    check("t4_outstanding", outstanding_o, 4'd1);

    // Write needs both AW and W
    do_reset();
    aw_valid_i = 1'b1; aw_addr_i = 32'h20; aw_id_i = 3'd4;
    w_data_i = 64'h1122_3344_5566_7788; w_strb_i = 8'hA6;
    for (int k = 0; k < 4; k++) begin
      check("t5_aw_ready_wait", aw_ready_o, 1'b0);
      check("t5_w_ready_wait", w_ready_o, 1'b0);
      step();
    end
    check("t5_no_cmd", cmd_valid_o, 1'b0);
    w_valid_i = 1'b1;
    #1;
    check("t5_aw_ready", aw_ready_o, 1'b1);
    check("t5_w_ready", w_ready_o, 1'b1);
    step();
    check("t5_cmd_valid", cmd_valid_o, 1'b1);
    check("t5_cmd_kind", cmd_read_o, 1'b0);
    check("t5_wdata_lo", cmd_wdata_o, 32'h5566_7788);
    check("t5_be_lo", cmd_be_o, 4'h6);
    check("t5_id", cmd_id_o, 3'd4);

    // Asynchronous reset while a command is pending and two are outstanding
    do_reset();
    ar_valid_i = 1'b1; ar_addr_i = 32'h50; cmd_ready_i = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      step();
      if (cmd_valid_o && outstanding_o == 4'd2) hit = 1'b1;
    end
    check("t6_reached", hit, 1'b1);
    #2;
    rst_ni = 1'b0;
    aw_valid_i = 1'b1; w_valid_i = 1'b1;
    #1;
    check("t6_rst_cmd_valid", cmd_valid_o, 1'b0);
    check("t6_rst_outstanding", outstanding_o, 4'd0);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_aw_ready", aw_ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mode_i = 1'b0;
    #1;
    check("t6_tie_ar_ready", ar_ready_o, 1'b1);
    check("t6_tie_aw_ready", aw_ready_o, 1'b0);
    step();
    check("t6_tie_read", cmd_read_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
